apb_protocol_checker: RTL and testbench

- Synthesizable, passive APB monitor/checker. Generalizes the interface-embedded assertions into parametrised RTL.
- Adds wait-state support with a timeout, sticky violation flags, and transfer, error and wait-statistics counters.
- Sits beside any APB requester/completer pair. It only samples bus signals and drives no bus signal.
- Outputs feed the scoreboard, the coverage collector and silicon debug registers.

---
 rtl/apb_protocol_checker.sv | 191 +++++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol monitor: phase tracking, rule violations, transfer/error/wait statistics.
// Optional read-data stability check and last_rdata capture enabled by APB_CHK_PRDATA_EN.
module apb_protocol_checker #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 16,
    parameter int CNT_W     = 16,
    parameter int ZERO_WAIT = 0
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr,
`ifdef APB_CHK_PRDATA_EN
    output logic [7:0]        viol_pulse,
    output logic [7:0]        viol_sticky,
    output logic [DATA_W-1:0] last_rdata,
`else
    output logic [6:0]        viol_pulse,
    output logic [6:0]        viol_sticky,
`endif
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  wait_max,
    output logic [1:0]        phase
);

`ifdef APB_CHK_PRDATA_EN
    localparam int VW = 8;
`else
    localparam int VW = 7;
`endif
    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    logic [1:0]        phase_reg, phase_next;
    logic [ADDR_W-1:0] paddr_q_reg;
    logic              pwrite_q_reg;
    logic [DATA_W-1:0] pwdata_q_reg;
    logic              cmpl_q_reg;
    logic              prev_valid_reg;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [VW-1:0]     viol_now;
    logic [VW-1:0]     viol_pulse_reg;
    logic [VW-1:0]     viol_sticky_reg, viol_sticky_next;
    logic [CNT_W-1:0]  xfer_cnt_reg, err_cnt_reg, wait_max_reg;

    logic              completion, wait_cycle, in_setup, in_wait, bus_changed, run_end;
    logic [CNT_W-1:0]  run_len;

    assign completion  = psel & penable & pready;
    assign wait_cycle  = psel & penable & ~pready;
    assign in_setup    = (phase_reg == PH_SETUP);
    // Previous sample was an ACCESS cycle that did not complete.
    assign in_wait     = (phase_reg == PH_ACCESS) & ~cmpl_q_reg;
    assign bus_changed = (paddr != paddr_q_reg) | (pwrite != pwrite_q_reg) |
                         (pwrite & (pwdata != pwdata_q_reg));
    assign run_end     = (wait_cnt_reg != '0) & ~wait_cycle;
    assign run_len     = CNT_W'(wait_cnt_reg);

    // Legal or not, the tracked phase always follows the decoded bus sample.
    always_comb begin
        phase_next = PH_IDLE;
        if (psel && !penable)
            phase_next = PH_SETUP;
        else if (psel && penable)
            phase_next = PH_ACCESS;
    end

    always_comb begin
        wait_cnt_next = '0;
        if (wait_cycle)
            wait_cnt_next = (wait_cnt_reg == WAIT_LIMIT) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
    end

    always_comb begin
        viol_now    = '0;
        viol_now[0] = penable & ~psel;
        viol_now[1] = penable & ((phase_reg == PH_IDLE) | ((phase_reg == PH_ACCESS) & cmpl_q_reg));
        viol_now[2] = prev_valid_reg & psel & penable & (in_setup | in_wait) & bus_changed;
        if (ZERO_WAIT != 0)
            viol_now[3] = wait_cycle & (wait_cnt_reg == '0);
        else
            viol_now[3] = wait_cycle & (wait_cnt_reg == WAIT_LAST);
        viol_now[4] = pslverr & ~completion;
        viol_now[5] = prev_valid_reg & cmpl_q_reg & penable;
        viol_now[6] = ~psel & (in_setup | in_wait);
`ifdef APB_CHK_PRDATA_EN
        viol_now[7] = prev_valid_reg & completion & ~pwrite & in_wait & (prdata != prdata_q_reg);
`endif
    end

    // A violation on the clearing cycle survives the clear.
    genvar gi;
    generate
        for (gi = 0; gi < VW; gi++) begin : g_sticky
            assign viol_sticky_next[gi] = viol_now[gi] | (viol_sticky_reg[gi] & ~clr);
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (prst) begin
            phase_reg       <= PH_IDLE;
            paddr_q_reg     <= '0;
            pwrite_q_reg    <= 1'b0;
            pwdata_q_reg    <= '0;
            cmpl_q_reg      <= 1'b0;
            prev_valid_reg  <= 1'b0;
            wait_cnt_reg    <= '0;
            viol_pulse_reg  <= '0;
            viol_sticky_reg <= '0;
        end else begin
            phase_reg       <= phase_next;
            paddr_q_reg     <= paddr;
            pwrite_q_reg    <= pwrite;
            pwdata_q_reg    <= pwdata;
            cmpl_q_reg      <= completion;
            prev_valid_reg  <= 1'b1;
            wait_cnt_reg    <= wait_cnt_next;
            viol_pulse_reg  <= viol_now;
            viol_sticky_reg <= viol_sticky_next;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            xfer_cnt_reg <= '0;
            err_cnt_reg  <= '0;
            wait_max_reg <= '0;
        end else begin
            if (completion)
                xfer_cnt_reg <= clr ? CNT_W'(1) :
                                (xfer_cnt_reg == CNT_MAX) ? xfer_cnt_reg : xfer_cnt_reg + 1'b1;
            else if (clr)
                xfer_cnt_reg <= '0;

            if (completion && pslverr)
                err_cnt_reg <= clr ? CNT_W'(1) :
                               (err_cnt_reg == CNT_MAX) ? err_cnt_reg : err_cnt_reg + 1'b1;
            else if (clr)
                err_cnt_reg <= '0;

            if (run_end && (clr || run_len > wait_max_reg))
                wait_max_reg <= run_len;
            else if (clr)
                wait_max_reg <= '0;
        end
    end

`ifdef APB_CHK_PRDATA_EN
    logic [DATA_W-1:0] prdata_q_reg;
    logic [DATA_W-1:0] last_rdata_reg;

    always_ff @(posedge pclk) begin
        if (prst) begin
            prdata_q_reg   <= '0;
            last_rdata_reg <= '0;
        end else begin
            prdata_q_reg <= prdata;
            if (completion && !pwrite)
                last_rdata_reg <= prdata;
        end
    end

    assign last_rdata = last_rdata_reg;
`else
    logic unused_prdata;
    assign unused_prdata = ^prdata;
`endif

    assign viol_pulse  = viol_pulse_reg;
    assign viol_sticky = viol_sticky_reg;
    assign xfer_cnt    = xfer_cnt_reg;
    assign err_cnt     = err_cnt_reg;
    assign wait_max    = wait_max_reg;
    assign phase       = phase_reg;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker (default build, default parameters).
module tb_apb_protocol_checker;

    logic       pclk = 1'b0;
    logic       prst, psel, penable, pwrite, pready, pslverr, clr;
    logic [7:0] paddr, pwdata, prdata;
    logic [6:0] viol_pulse, viol_sticky;
    logic [15:0] xfer_cnt, err_cnt, wait_max;
    logic [1:0] phase;

    int compared   = 0;
    int mismatched = 0;

    apb_protocol_checker dut (
        .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .clr(clr), .viol_pulse(viol_pulse), .viol_sticky(viol_sticky),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .wait_max(wait_max), .phase(phase)
    );

    always #5 pclk = ~pclk;

    // Apply one bus sample, clock it, and settle just after the edge.
    task automatic drive(input logic sel, input logic en, input logic wr,
                         input logic [7:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                         input logic rdy, input logic err, input logic cl);
        psel = sel; penable = en; pwrite = wr; paddr = addr; pwdata = wd;
        prdata = rd; pready = rdy; pslverr = err; clr = cl;
        @(posedge pclk);
        #1;
        $display("t=%0t sel=%0b en=%0b wr=%0b addr=%02h rdy=%0b err=%0b clr=%0b rst=%0b -> phase=%0d viol=%02h sticky=%02h xfer=%0d errc=%0d wmax=%0d",
                 $time, sel, en, wr, addr, rdy, err, cl, prst, phase, viol_pulse, viol_sticky,
                 xfer_cnt, err_cnt, wait_max);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},  32'(phase), 32'h0);
        check({tag, "_viol"},   32'(viol_pulse), 32'h0);
        check({tag, "_sticky"}, 32'(viol_sticky), 32'h0);
        check({tag, "_xfer"},   32'(xfer_cnt), 32'h0);
        check({tag, "_err"},    32'(err_cnt), 32'h0);
        check({tag, "_wmax"},   32'(wait_max), 32'h0);
    endtask

    initial begin
        prst = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check_all_zero("reset");
        prst = 1'b0;
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("post_reset_viol", 32'(viol_pulse), 32'h0);

        // Zero-wait write 0x3C to 0x10
        drive(1, 0, 1, 8'h10, 8'h3C, 8'h00, 0, 0, 0);
        check("wr_setup_phase", 32'(phase), 32'd1);
        drive(1, 1, 1, 8'h10, 8'h3C, 8'h00, 1, 0, 0);
        check("wr_access_phase", 32'(phase), 32'd2);
        check("wr_access_xfer", 32'(xfer_cnt), 32'd1);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("wr_idle_phase", 32'(phase), 32'd0);
        check("wr_viol", 32'(viol_sticky), 32'h0);

        // Clear, then read with 3 wait cycles
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        check("clr_xfer", 32'(xfer_cnt), 32'd0);
        drive(1, 0, 0, 8'h20, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 8'h20, 8'h00, 8'hA5, 0, 0, 0);
            check("rd_wait_viol", 32'(viol_pulse), 32'h0);
        end
        drive(1, 1, 0, 8'h20, 8'h00, 8'hA5, 1, 0, 0);
        check("rd_wait_max", 32'(wait_max), 32'd3);
        check("rd_xfer", 32'(xfer_cnt), 32'd1);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("rd_sticky", 32'(viol_sticky), 32'h0);

        // Timeout: 17 wait cycles, pulse only after the 16th
        drive(1, 0, 0, 8'h30, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 8'h30, 8'h00, 8'h00, 0, 0, 0);
            check($sformatf("timeout_pulse_%0d", i), 32'(viol_pulse), (i == 15) ? 32'h08 : 32'h0);
        end
        drive(1, 1, 0, 8'h30, 8'h00, 8'h00, 1, 0, 0);
        check("timeout_done_viol", 32'(viol_pulse), 32'h0);
        check("timeout_sticky", 32'(viol_sticky), 32'h08);
        check("timeout_wait_max", 32'(wait_max), 32'd16);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // Address change during a wait cycle
        drive(1, 0, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0);
        drive(1, 1, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0);
        check("addr_wait1_viol", 32'(viol_pulse), 32'h0);
        drive(1, 1, 0, 8'h11, 8'h00, 8'h00, 0, 0, 0);
        check("addr_change_viol", 32'(viol_pulse), 32'h04);
        drive(1, 1, 0, 8'h11, 8'h00, 8'h00, 1, 0, 0);
        check("addr_done_viol", 32'(viol_pulse), 32'h0);
        check("addr_sticky", 32'(viol_sticky), 32'h0C);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        // Clear, then penable without psel from IDLE
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        check("clr2_sticky", 32'(viol_sticky), 32'h0);
        check("clr2_wait_max", 32'(wait_max), 32'd0);
        drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("en_nosel_viol", 32'(viol_pulse), 32'h03);
        check("en_nosel_phase", 32'(phase), 32'd0);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("en_nosel_after", 32'(viol_pulse), 32'h0);
        check("en_nosel_sticky", 32'(viol_sticky), 32'h03);

        // Error completion with clr, plus an address change SETUP->ACCESS on the same cycle
        drive(1, 0, 1, 8'h40, 8'h55, 8'h00, 0, 0, 0);
        drive(1, 1, 1, 8'h41, 8'h55, 8'h00, 1, 1, 1);
        check("errclr_err", 32'(err_cnt), 32'd1);
        check("errclr_xfer", 32'(xfer_cnt), 32'd1);
        check("errclr_sticky", 32'(viol_sticky), 32'h04);
        check("errclr_viol", 32'(viol_pulse), 32'h04);
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("errclr_after", 32'(viol_pulse), 32'h0);

        // pslverr on a wait cycle, then reset mid-ACCESS
        drive(1, 0, 0, 8'h50, 8'h00, 8'h00, 0, 0, 0);
        drive(1, 1, 0, 8'h50, 8'h00, 8'h00, 0, 1, 0);
        check("slverr_wait_viol", 32'(viol_pulse), 32'h10);
        prst = 1'b1;
        drive(1, 1, 0, 8'h50, 8'h00, 8'h00, 0, 0, 0);
        check_all_zero("midreset");
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        prst = 1'b0;
        drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("after_reset_viol", 32'(viol_pulse), 32'h0);
        check("after_reset_sticky", 32'(viol_sticky), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
